serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial WIDTH-bit subtractor: computes a - b - bin one bit per clock, LSB first.
//   Each bit is computed by a single 1-bit full-subtractor cell:
//     diff = a^b^c, br = (~a&b) | (~(a^b)&c).
//   The borrow is carried between cycles in a flip-flop.
//   Sits downstream of the combinational full_sub cell as its sequential consumer.
//   Trades latency for area in the arithmetic datapath.
// PARAMETERS
//   WIDTH   8   operand/result width in bits (>= 2)
// PORTS
//   clk         input   1       rising-edge clock
//   rst         input   1       synchronous, active-high reset
//   start       input   1       request: load a_in/b_in/bin and begin
//   a_in        input   WIDTH   minuend
//   b_in        input   WIDTH   subtrahend
//   bin         input   1       borrow in (for chaining words)
//   busy        output  1       high while bits are being processed
//   done        output  1       one-cycle pulse: diff_out/borrow_out just updated
//   diff_out    output  WIDTH   result (a_in - b_in - bin) mod 2^WIDTH
//   borrow_out  output  1       final borrow: 1 iff a_in < b_in + bin
// BEHAVIOUR
//   Reset
//     - rst sampled high at a clk edge -> state IDLE.
//     - busy=0, done=0, diff_out=0, borrow_out=0.
//     - Shift registers, bit counter and borrow FF are cleared.
//     - rst has priority over start.
//   FSM states: IDLE, SHIFT, DONE
//     - IDLE: start=1 -> capture a_in, b_in into shift regs and bin into the borrow FF.
//       Set count=0 and go to SHIFT.
//     - SHIFT: each edge processes bit[count].
//       - Shift diff bit into the result shift reg (MSB side); shift a/b regs right.
//       - Borrow FF <= br; count <= count+1.
//       - On the edge that processes bit WIDTH-1: diff_out <= assembled result,
//         borrow_out <= final br, go to DONE.
//     - DONE: done=1 for exactly this cycle.
//       - start=1 -> reload and go to SHIFT (back-to-back).
//       - else -> IDLE.
//   Timing
//     - busy=1 exactly in SHIFT (WIDTH cycles).
//     - Latency: start sampled at edge E0 -> done high in the cycle after edge E(WIDTH).
//     - Throughput: one operation per WIDTH+1 cycles.
//   Handshake
//     - start is ignored while busy=1.
//     - Operands are sampled only at the accepting edge; later a_in/b_in changes have no effect.
//   Outputs
//     - diff_out/borrow_out change only at completion.
//     - They hold the last result through IDLE and the next operation, until it completes.
//   Arithmetic
//     - Pure modulo-2^WIDTH wrap; no saturation.
//     - borrow_out equals the borrow out of bit WIDTH-1.
//   Reset mid-operation
//     - Aborts immediately with the reset values above.
//     - No done pulse; the partial result is discarded.
//   Counter width: $clog2(WIDTH); it must not wrap before reaching WIDTH-1.
// TESTING
//   1. WIDTH=8, a=200, b=55, bin=0, start 1 cycle -> busy 8 cycles, then done=1, diff_out=145, borrow_out=0.
//   2. a=5, b=10, bin=0 -> diff_out=251 (0xFB), borrow_out=1; done pulse exactly 1 cycle.
//   3. a=0, b=0, bin=1 -> diff_out=255, borrow_out=1. a=0x80, b=0x80, bin=0 -> diff_out=0, borrow_out=0.
//   4. Pulse start again at cycle 3 of SHIFT with new operands -> ignored; result matches first operands only.
//   5. Hold start high through DONE -> second op starts back-to-back; second done 9 cycles after first.
//   6. Assert rst at cycle 4 of SHIFT -> next cycle busy=0, diff_out=0, no done.
//      Then WIDTH=4 exhaustive: all a,b,bin -> {borrow_out,diff_out} == a-b-bin (5-bit two's complement).

Source files
------------

// File: rtl/serial_subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_subtractor: bit-serial a - b - bin, one bit per clock, LSB first   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff_out,
   output logic             borrow_out
);

   localparam int            CW     = $clog2(WIDTH);
   localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);
   localparam logic [CW-1:0] c_one  = CW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [CW-1:0]    r_cnt;
   logic             r_brw;
   logic             w_load;
   logic             w_last;
   logic             w_d;
   logic             w_br;
   logic [WIDTH-1:0] w_res_next;

   // single full-subtractor cell working on the current LSBs
   assign w_d        = r_a[0] ^ r_b[0] ^ r_brw;
   assign w_br       = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_brw);
   assign w_res_next = {w_d, r_res[WIDTH-1:1]};
   assign w_last     = (r_cnt == c_last);
   assign w_load     = start && (r_state != SHIFT);

   assign busy = (r_state == SHIFT);
   assign done = (r_state == DONE);

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = SHIFT;
         SHIFT:   if (w_last) w_next = DONE;
         DONE:    w_next = start ? SHIFT : IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a        <= '0;
         r_b        <= '0;
         r_res      <= '0;
         r_cnt      <= '0;
         r_brw      <= 1'b0;
         diff_out   <= '0;
         borrow_out <= 1'b0;
      end else if (w_load) begin
         r_a   <= a_in;
         r_b   <= b_in;
         r_brw <= bin;
         r_cnt <= '0;
      end else if (busy) begin
         r_a   <= r_a >> 1;
         r_b   <= r_b >> 1;
         r_res <= w_res_next;
         r_brw <= w_br;
         r_cnt <= r_cnt + c_one;
         // results are published only when the MSB has been processed
         if (w_last) begin
            diff_out   <= w_res_next;
            borrow_out <= w_br;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// Testbench for serial_subtractor: directed and random checks at WIDTH=8,
// exhaustive checks at WIDTH=4, against an arithmetic reference model.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       bin8 = 1'b0;
   logic       busy8, done8, bout8;
   logic [7:0] diff8;

   logic       start4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       bin4 = 1'b0;
   logic       busy4, done4, bout4;
   logic [3:0] diff4;

   int n_chk  = 0;
   int n_pass = 0;
   int last_d = 0;
   int last_b = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .bin(bin8),
      .busy(busy8), .done(done8), .diff_out(diff8), .borrow_out(bout8));

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4), .bin(bin4),
      .busy(busy4), .done(done4), .diff_out(diff4), .borrow_out(bout4));

   // reference: {borrow, diff} of a - b - bin in w bits
   function automatic int ref_diff(int w, int a, int b, int bi);
      return (a - b - bi) & ((1 << w) - 1);
   endfunction
   function automatic int ref_borrow(int a, int b, int bi);
      return (a < b + bi) ? 1 : 0;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // one WIDTH=8 operation; glitch>=0 pulses start with other operands at that SHIFT cycle
   task automatic op8(int a, int b, int bi, int glitch);
      int ed, eb;
      ed = ref_diff(8, a, b, bi);
      eb = ref_borrow(a, b, bi);
      start8 = 1'b1; a8 = 8'(a); b8 = 8'(b); bin8 = bi[0];
      step();
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      chk("hold_diff", 32'(diff8), 32'(last_d));
      chk("hold_borrow", 32'(bout8), 32'(last_b));
      for (int i = 0; i < 8; i++) begin
         chk("busy", 32'(busy8), 32'd1);
         chk("no_done", 32'(done8), 32'd0);
         start8 = (i == glitch);
         step();
         start8 = 1'b0;
      end
      chk("done", 32'(done8), 32'd1);
      chk("busy_off", 32'(busy8), 32'd0);
      chk("diff", 32'(diff8), 32'(ed));
      chk("borrow", 32'(bout8), 32'(eb));
      last_d = ed;
      last_b = eb;
   endtask

   task automatic idle8();
      step();
      chk("done_pulse", 32'(done8), 32'd0);
      chk("idle_busy", 32'(busy8), 32'd0);
      chk("idle_diff", 32'(diff8), 32'(last_d));
   endtask

   initial begin
      int a, b, bi;
      rst = 1'b1;
      step();
      step();
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_done", 32'(done8), 32'd0);
      chk("rst_diff", 32'(diff8), 32'd0);
      chk("rst_borrow", 32'(bout8), 32'd0);
      // rst has priority over start
      start8 = 1'b1;
      step();
      chk("rst_prio", 32'(busy8), 32'd0);
      start8 = 1'b0;
      rst = 1'b0;
      step();

      op8(200, 55, 0, -1);  idle8();
      op8(5, 10, 0, -1);    idle8();
      op8(0, 0, 1, -1);     idle8();
      op8(8'h80, 8'h80, 0, -1); idle8();
      op8(255, 0, 0, -1);   idle8();
      op8(37, 90, 1, 3);    idle8();
      // back-to-back: start presented while DONE
      op8(100, 1, 1, -1);
      op8(3, 200, 0, -1);   idle8();

      // reset in the middle of SHIFT
      start8 = 1'b1; a8 = 8'd77; b8 = 8'd12; bin8 = 1'b0;
      step();
      start8 = 1'b0;
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_busy", 32'(busy8), 32'd0);
      chk("mid_rst_done", 32'(done8), 32'd0);
      chk("mid_rst_diff", 32'(diff8), 32'd0);
      chk("mid_rst_borrow", 32'(bout8), 32'd0);
      last_d = 0;
      last_b = 0;
      repeat (9) begin
         step();
         chk("mid_rst_nodone", 32'(done8), 32'd0);
      end

      for (int k = 0; k < 40; k++) begin
         a  = int'($urandom_range(255, 0));
         b  = int'($urandom_range(255, 0));
         bi = int'($urandom_range(1, 0));
         op8(a, b, bi, ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 0)) : -1);
         if ($urandom_range(1, 0) == 1) idle8();
      end
      idle8();

      // WIDTH=4 exhaustive, run back-to-back
      for (int x = 0; x < 512; x++) begin
         a = x & 15;
         b = (x >> 4) & 15;
         bi = (x >> 8) & 1;
         start4 = 1'b1; a4 = 4'(a); b4 = 4'(b); bin4 = bi[0];
         step();
         start4 = 1'b0;
         repeat (4) step();
         chk("w4_done", 32'(done4), 32'd1);
         chk("w4_result", {27'd0, bout4, diff4}, 32'((a - b - bi) & 31));
      end
      step();
      chk("w4_idle", 32'(done4), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
